// File: rtl/hex_display_scan_ctrl_pkg.sv
// Shared constants and types for the hex display scan controller.
package hex_display_scan_ctrl_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Index width for a digit counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_scan_ctrl_if.sv
// Producer-facing bus of the scan controller: load handshake plus segment outputs.
interface hex_display_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
);
  import hex_display_scan_ctrl_pkg::*;

  logic                      i_load;
  logic [4*N_DIGITS-1:0]     i_value;
  logic                      o_ready;
  logic                      o_done;
  logic [SEG_W*N_DIGITS-1:0] o_hex;

  modport master (
    output i_load,
    output i_value,
    input  o_ready,
    input  o_done,
    input  o_hex
  );

  modport slave (
    input  i_load,
    input  i_value,
    output o_ready,
    output o_done,
    output o_hex
  );

endinterface

// File: rtl/hex_display_scan_ctrl_hex_decoder.sv
// Nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_decoder
  import hex_display_scan_ctrl_pkg::*;
(
  input  logic [3:0]       i_num,
  output logic [SEG_W-1:0] o_seg7
);

  always_comb begin
    o_seg7 = SEG_BLANK;
    case (i_num)
      4'h0: o_seg7 = 7'h40;
      4'h1: o_seg7 = 7'h79;
      4'h2: o_seg7 = 7'h24;
      4'h3: o_seg7 = 7'h30;
      4'h4: o_seg7 = 7'h19;
      4'h5: o_seg7 = 7'h12;
      4'h6: o_seg7 = 7'h02;
      4'h7: o_seg7 = 7'h78;
      4'h8: o_seg7 = 7'h00;
      4'h9: o_seg7 = 7'h10;
      4'hA: o_seg7 = 7'h08;
      4'hB: o_seg7 = 7'h03;
      4'hC: o_seg7 = 7'h46;
      4'hD: o_seg7 = 7'h21;
      4'hE: o_seg7 = 7'h06;
      4'hF: o_seg7 = 7'h0E;
      default: o_seg7 = 7'bxxxxxxx;
    endcase
  end

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Walks a captured hex value MSB-first through one shared decoder into a shadow
// register, then commits every digit to the pins on a single edge.
module hex_display_scan_ctrl
  import hex_display_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic                     i_clk,
  input logic                     i_reset,
  hex_display_scan_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(N_DIGITS);

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      seen_nz_q;
  logic [4*N_DIGITS-1:0]     value_q;
  logic [SEG_W-1:0]          shadow_q [N_DIGITS];
  logic [SEG_W*N_DIGITS-1:0] hex_q;
  logic                      done_q;

  logic [3:0]       nibble_c;
  logic [SEG_W-1:0] seg_c;
  logic             blank_c;

  assign nibble_c = value_q[{idx_q, 2'b00} +: 4];
  assign blank_c  = BLANK_LZ && (nibble_c == 4'h0) && !seen_nz_q && (idx_q != '0);

  hex_decoder u_hex_decoder (
    .i_num  (nibble_c),
    .o_seg7 (seg_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      seen_nz_q <= 1'b0;
      value_q   <= '0;
      hex_q     <= '1;
      done_q    <= 1'b0;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        shadow_q[k] <= SEG_BLANK;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_load) begin
            value_q   <= bus.i_value;
            idx_q     <= IDX_W'(N_DIGITS - 1);
            seen_nz_q <= 1'b0;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          shadow_q[idx_q] <= blank_c ? SEG_BLANK : seg_c;
          seen_nz_q       <= seen_nz_q | (nibble_c != 4'h0);
          // Digit 0 is the last one scanned, so idx never underflows.
          if (idx_q == '0) begin
            state_q <= ST_COMMIT;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          for (int unsigned k = 0; k < N_DIGITS; k++) begin
            hex_q[SEG_W*k +: SEG_W] <= shadow_q[k];
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_done  = done_q;
  assign bus.o_hex   = hex_q;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Randomized and directed checks of the scan controller against a transaction-level model.
module tb_hex_display_scan_ctrl;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  hex_display_scan_ctrl_if #(.N_DIGITS(N)) bus_a ();
  hex_display_scan_ctrl_if #(.N_DIGITS(N)) bus_b ();

  hex_display_scan_ctrl #(.N_DIGITS(N), .BLANK_LZ(1'b1)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_a)
  );

  hex_display_scan_ctrl #(.N_DIGITS(N), .BLANK_LZ(1'b0)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  // Segment table written independently of the design's decoder.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: remaining busy cycles, captured value, expected pins.
  int          busy = 0;
  logic [15:0] pend = '0;
  logic [27:0] exp_hex_a = '1;
  logic [27:0] exp_hex_b = '1;
  logic        exp_done = 1'b0;
  int          done_cycles [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  // Digits above the most significant nonzero nibble are blank when blanking is on.
  function automatic logic [27:0] ref_hex(input logic [15:0] v, input bit blank);
    logic [27:0] r;
    int top = 0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) top = k;
    for (int k = 0; k < 4; k++) begin
      if (blank && k > top) r[7*k +: 7] = 7'h7F;
      else                  r[7*k +: 7] = seg_tab[v[4*k +: 4]];
    end
    return r;
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic r);
    @(negedge clk);
    rst           = r;
    bus_a.i_load  = ld;
    bus_a.i_value = v;
    bus_b.i_load  = ld;
    bus_b.i_value = v;
    @(posedge clk);
    cycle++;
    exp_done = 1'b0;
    if (r) begin
      busy      = 0;
      exp_hex_a = '1;
      exp_hex_b = '1;
    end else if (busy == 0) begin
      if (ld) begin
        pend = v;
        busy = N + 1;
      end
    end else begin
      busy--;
      if (busy == 0) begin
        exp_hex_a = ref_hex(pend, 1'b1);
        exp_hex_b = ref_hex(pend, 1'b0);
        exp_done  = 1'b1;
      end
    end
    #1;
    if (bus_a.o_done === 1'b1) done_cycles.push_back(cycle);
    check("ready_a", 32'(bus_a.o_ready), 32'(busy == 0));
    check("done_a",  32'(bus_a.o_done),  32'(exp_done));
    check("hex_a",   32'(bus_a.o_hex),   32'(exp_hex_a));
    check("ready_b", 32'(bus_b.o_ready), 32'(busy == 0));
    check("done_b",  32'(bus_b.o_done),  32'(exp_done));
    check("hex_b",   32'(bus_b.o_hex),   32'(exp_hex_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] mask;
    bus_a.i_load = 1'b0; bus_a.i_value = '0;
    bus_b.i_load = 1'b0; bus_b.i_value = '0;

    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'hBEEF, 1'b1);
    check("reset_hex", 32'(bus_a.o_hex), 32'(28'hFFFFFFF));
    check("reset_ready", 32'(bus_a.o_ready), 32'd1);

    step(1'b1, 16'h0A3F, 1'b0); idle(5);
    check("vec_0A3F", 32'(bus_a.o_hex), 32'({7'h7F, 7'h08, 7'h30, 7'h0E}));

    step(1'b1, 16'h0000, 1'b0); idle(5);
    check("vec_0000", 32'(bus_a.o_hex), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    step(1'b1, 16'h1008, 1'b0); idle(5);
    check("vec_1008_noblank", 32'(bus_b.o_hex), 32'({7'h79, 7'h40, 7'h40, 7'h00}));

    step(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("vec_1234_ignore", 32'(bus_a.o_hex), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

    step(1'b0, 16'h0000, 1'b1);
    done_cycles.delete();
    step(1'b1, 16'h5678, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(6);
    check("reset_mid_scan_hex", 32'(bus_a.o_hex), 32'(28'hFFFFFFF));
    check("reset_mid_scan_done", 32'(done_cycles.size()), 32'd0);

    done_cycles.delete();
    step(1'b1, 16'h0001, 1'b0); idle(5);
    step(1'b1, 16'h00F0, 1'b0); idle(5);
    check("b2b_pulses", 32'(done_cycles.size()), 32'd2);
    if (done_cycles.size() == 2)
      check("b2b_spacing", 32'(done_cycles[1] - done_cycles[0]), 32'd6);
    check("b2b_hex", 32'(bus_a.o_hex), 32'({7'h7F, 7'h7F, 7'h0E, 7'h40}));

    // Random traffic with varied leading-zero counts and occasional resets.
    for (int i = 0; i < 600; i++) begin
      mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
      v    = 16'($urandom) & mask;
      step(($urandom_range(0, 2) == 0), v, ($urandom_range(0, 63) == 0));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
